// File: rtl/pool_window_sched.sv
// Sequencing controller for max pooling over a square feature map.
// It walks each stride-aligned window of an external single-port buffer,
// issuing one read per cycle, and keeps a running signed maximum of the
// returned words. Each window maximum is then offered on a valid/ready port.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_start              request to process one map (ignored while busy)
//   o_busy, o_done       map in progress / one-cycle completion pulse
//   o_rd_en, o_rd_addr   buffer read strobe and word address
//   i_rd_data            buffer read data, one cycle after o_rd_en
//   o_out_valid, i_out_ready, o_out_data, o_out_addr   window result port
module pool_window_sched #(
    parameter int unsigned INPUT_SIZE   = 8,
    parameter int unsigned POOLING_SIZE = 2,
    localparam int unsigned OUT_SIDE = INPUT_SIZE / POOLING_SIZE,
    localparam int unsigned AW = (INPUT_SIZE * INPUT_SIZE > 1) ? $clog2(INPUT_SIZE * INPUT_SIZE) : 1,
    localparam int unsigned OW = (OUT_SIDE * OUT_SIDE > 1) ? $clog2(OUT_SIDE * OUT_SIDE) : 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic [31:0]   i_rd_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [31:0]   o_out_data,
    output logic [OW-1:0] o_out_addr
);

    localparam int unsigned KW = (POOLING_SIZE > 1) ? $clog2(POOLING_SIZE) : 1;
    localparam int unsigned WW = (OUT_SIDE > 1) ? $clog2(OUT_SIDE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_FLUSH,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t        r_state;
    logic [WW-1:0] r_wr;
    logic [WW-1:0] r_wc;
    logic [KW-1:0] r_kr;
    logic [KW-1:0] r_kc;
    logic          r_rd_first;
    logic          r_cap_vld;
    logic          r_cap_first;
    logic [31:0]   r_max;

    state_t        w_state_nxt;
    logic [WW-1:0] w_wr_nxt;
    logic [WW-1:0] w_wc_nxt;
    logic [KW-1:0] w_kr_nxt;
    logic [KW-1:0] w_kc_nxt;
    logic [31:0]   w_max_nxt;
    logic          w_rd_en_nxt;
    logic          w_rd_first_nxt;
    logic [AW-1:0] w_rd_addr_nxt;
    logic          w_out_valid_nxt;
    logic [31:0]   w_out_data_nxt;
    logic [OW-1:0] w_out_addr_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;

    // Next state, counters and the registered-output values derived from them
    always_comb begin
        w_state_nxt = r_state;
        w_wr_nxt    = r_wr;
        w_wc_nxt    = r_wc;
        w_kr_nxt    = r_kr;
        w_kc_nxt    = r_kc;
        w_max_nxt   = r_max;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_READ;
                    w_wr_nxt    = '0;
                    w_wc_nxt    = '0;
                    w_kr_nxt    = '0;
                    w_kc_nxt    = '0;
                end
            end
            ST_READ: begin
                if (r_kc == KW'(POOLING_SIZE - 1)) begin
                    w_kc_nxt = '0;
                    if (r_kr == KW'(POOLING_SIZE - 1)) begin
                        w_kr_nxt    = '0;
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_kr_nxt = r_kr + KW'(1);
                    end
                end else begin
                    w_kc_nxt = r_kc + KW'(1);
                end
            end
            ST_FLUSH: w_state_nxt = ST_OUT;
            ST_OUT: begin
                if (i_out_ready) begin
                    w_state_nxt = ST_READ;
                    if (r_wc == WW'(OUT_SIDE - 1)) begin
                        w_wc_nxt = '0;
                        if (r_wr == WW'(OUT_SIDE - 1)) begin
                            w_wr_nxt    = '0;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_wr_nxt = r_wr + WW'(1);
                        end
                    end else begin
                        w_wc_nxt = r_wc + WW'(1);
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        // Returning word: first element of a window loads, later ones win only if strictly greater
        if (r_cap_vld && (r_cap_first || ($signed(i_rd_data) > $signed(r_max)))) begin
            w_max_nxt = i_rd_data;
        end

        w_rd_en_nxt     = (w_state_nxt == ST_READ);
        w_rd_first_nxt  = w_rd_en_nxt && (w_kr_nxt == '0) && (w_kc_nxt == '0);
        w_rd_addr_nxt   = w_rd_en_nxt
                        ? AW'((32'(w_wr_nxt) * POOLING_SIZE + 32'(w_kr_nxt)) * INPUT_SIZE
                              + 32'(w_wc_nxt) * POOLING_SIZE + 32'(w_kc_nxt))
                        : o_rd_addr;
        w_out_valid_nxt = (w_state_nxt == ST_OUT);
        w_out_data_nxt  = w_out_valid_nxt ? w_max_nxt : o_out_data;
        w_out_addr_nxt  = w_out_valid_nxt ? OW'(32'(w_wr_nxt) * OUT_SIDE + 32'(w_wc_nxt)) : o_out_addr;
        w_busy_nxt      = (w_state_nxt == ST_READ) || (w_state_nxt == ST_FLUSH) || (w_state_nxt == ST_OUT);
        w_done_nxt      = (w_state_nxt == ST_DONE);
    end

    // State, counters, capture pipeline and outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_wr        <= '0;
            r_wc        <= '0;
            r_kr        <= '0;
            r_kc        <= '0;
            r_rd_first  <= 1'b0;
            r_cap_vld   <= 1'b0;
            r_cap_first <= 1'b0;
            r_max       <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_rd_en     <= 1'b0;
            o_rd_addr   <= '0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr        <= w_wr_nxt;
            r_wc        <= w_wc_nxt;
            r_kr        <= w_kr_nxt;
            r_kc        <= w_kc_nxt;
            r_rd_first  <= w_rd_first_nxt;
            r_cap_vld   <= o_rd_en;
            r_cap_first <= r_rd_first;
            r_max       <= w_max_nxt;
            o_busy      <= w_busy_nxt;
            o_done      <= w_done_nxt;
            o_rd_en     <= w_rd_en_nxt;
            o_rd_addr   <= w_rd_addr_nxt;
            o_out_valid <= w_out_valid_nxt;
            o_out_data  <= w_out_data_nxt;
            o_out_addr  <= w_out_addr_nxt;
        end
    end

endmodule

// File: tb/tb_pool_window_sched.sv
// Bench for pool_window_sched: a 4x4/2 instance and a 5x5/2 instance share one
// buffer image; a behavioural model computes window maxima, read order and
// cycle timing from the map contents and the out_ready pattern.
module tb_pool_window_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ready;
    logic        sel;

    logic        a_start, a_busy, a_done, a_rd_en, a_out_valid;
    logic [3:0]  a_rd_addr;
    logic [31:0] a_rd_data, a_out_data;
    logic [1:0]  a_out_addr;

    logic        b_start, b_busy, b_done, b_rd_en, b_out_valid;
    logic [4:0]  b_rd_addr;
    logic [31:0] b_rd_data, b_out_data;
    logic [1:0]  b_out_addr;

    logic        m_busy, m_done, m_rd_en, m_out_valid;
    logic [4:0]  m_rd_addr;
    logic [31:0] m_out_data;
    logic [1:0]  m_out_addr;

    logic [31:0] mem [0:24];
    bit          rdy [0:511];
    logic [31:0] res_data [$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign a_start = start & ~sel;
    assign b_start = start & sel;

    pool_window_sched #(.INPUT_SIZE(4), .POOLING_SIZE(2)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_start(a_start),
        .o_busy(a_busy), .o_done(a_done),
        .o_rd_en(a_rd_en), .o_rd_addr(a_rd_addr), .i_rd_data(a_rd_data),
        .o_out_valid(a_out_valid), .i_out_ready(ready),
        .o_out_data(a_out_data), .o_out_addr(a_out_addr)
    );

    pool_window_sched #(.INPUT_SIZE(5), .POOLING_SIZE(2)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_start(b_start),
        .o_busy(b_busy), .o_done(b_done),
        .o_rd_en(b_rd_en), .o_rd_addr(b_rd_addr), .i_rd_data(b_rd_data),
        .o_out_valid(b_out_valid), .i_out_ready(ready),
        .o_out_data(b_out_data), .o_out_addr(b_out_addr)
    );

    // Single-port buffer: data one cycle after the strobe, junk otherwise
    always @(posedge clk) begin
        a_rd_data <= a_rd_en ? mem[a_rd_addr] : 32'hDEADBEEF;
        b_rd_data <= b_rd_en ? mem[b_rd_addr] : 32'hDEADBEEF;
    end

    always_comb begin
        m_busy      = sel ? b_busy      : a_busy;
        m_done      = sel ? b_done      : a_done;
        m_rd_en     = sel ? b_rd_en     : a_rd_en;
        m_rd_addr   = sel ? b_rd_addr   : {1'b0, a_rd_addr};
        m_out_valid = sel ? b_out_valid : a_out_valid;
        m_out_data  = sel ? b_out_data  : a_out_data;
        m_out_addr  = sel ? b_out_addr  : a_out_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem_random();
        for (int i = 0; i < 25; i++) mem[i] = $urandom();
    endtask

    task automatic fill_rdy(input int pct_low);
        for (int i = 0; i < 512; i++) rdy[i] = (i >= 300) || ($urandom_range(0, 99) >= pct_low);
    endtask

    // Process one map on the selected instance and compare against the model
    task automatic run_map(input bit use_b, input int extra_start);
        int n, os, t, done_exp, done_cyc;
        int q_addr[$], q_rdc[$], q_vc[$], q_ac[$];
        logic [31:0] q_max[$];
        int g_addr[$], g_rdc[$], g_vc[$], g_ac[$], g_oa[$];
        logic [31:0] g_od[$];
        logic [31:0] mx, v, hold_d;
        logic [1:0]  hold_a;
        bit first, in_wait;

        sel = use_b;
        n   = use_b ? 5 : 4;
        os  = n / 2;

        // Reference: window order, running signed max, cycle timeline
        t = 1;
        for (int wr = 0; wr < os; wr++) begin
            for (int wc = 0; wc < os; wc++) begin
                first = 1'b1;
                mx    = '0;
                for (int kr = 0; kr < 2; kr++) begin
                    for (int kc = 0; kc < 2; kc++) begin
                        int a;
                        a = (wr * 2 + kr) * n + wc * 2 + kc;
                        q_addr.push_back(a);
                        q_rdc.push_back(t);
                        t++;
                        v = mem[a];
                        if (first || ($signed(v) > $signed(mx))) mx = v;
                        first = 1'b0;
                    end
                end
                q_max.push_back(mx);
                t++;
                q_vc.push_back(t);
                while (!rdy[t] && t < 511) t++;
                q_ac.push_back(t);
                t++;
            end
        end
        done_exp = t;

        @(negedge clk);
        start = 1'b1;
        ready = rdy[0];
        @(negedge clk);
        start    = 1'b0;
        done_cyc = -1;
        in_wait  = 1'b0;
        hold_d   = '0;
        hold_a   = '0;
        for (int c = 1; c < 480 && done_cyc < 0; c++) begin
            ready = rdy[c];
            start = (c == extra_start);
            if (m_rd_en) begin
                g_addr.push_back(int'(m_rd_addr));
                g_rdc.push_back(c);
            end
            if (m_out_valid) begin
                chk("no_read_during_out", 32'(m_rd_en), 32'd0);
                if (in_wait) begin
                    chk("hold_data", m_out_data, hold_d);
                    chk("hold_addr", 32'(m_out_addr), 32'(hold_a));
                end else begin
                    g_vc.push_back(c);
                    g_oa.push_back(int'(m_out_addr));
                    g_od.push_back(m_out_data);
                    hold_d  = m_out_data;
                    hold_a  = m_out_addr;
                    in_wait = 1'b1;
                end
                if (ready) begin
                    g_ac.push_back(c);
                    in_wait = 1'b0;
                end
            end
            chk("busy", 32'(m_busy), 32'(!m_done));
            if (m_done) done_cyc = c;
            else @(negedge clk);
        end
        start = 1'b0;

        chk("done_seen", 32'(done_cyc >= 0), 32'd1);
        chk("done_cycle", 32'(done_cyc), 32'(done_exp));
        chk("n_reads", 32'(g_addr.size()), 32'(q_addr.size()));
        for (int i = 0; i < g_addr.size() && i < q_addr.size(); i++) begin
            chk("rd_addr", 32'(g_addr[i]), 32'(q_addr[i]));
            chk("rd_cycle", 32'(g_rdc[i]), 32'(q_rdc[i]));
            chk("rd_in_region", 32'(((g_addr[i] % n) < 2 * os) && ((g_addr[i] / n) < 2 * os)), 32'd1);
        end
        chk("n_results", 32'(g_od.size()), 32'(q_max.size()));
        res_data = g_od;
        for (int k = 0; k < g_od.size() && k < q_max.size(); k++) begin
            chk("out_addr", 32'(g_oa[k]), 32'(k));
            chk("out_data", g_od[k], q_max[k]);
            chk("valid_cycle", 32'(g_vc[k]), 32'(q_vc[k]));
        end
        for (int k = 0; k < g_ac.size() && k < q_ac.size(); k++)
            chk("accept_cycle", 32'(g_ac[k]), 32'(q_ac[k]));

        @(negedge clk);
        chk("idle_busy", 32'(m_busy), 32'd0);
        chk("idle_done", 32'(m_done), 32'd0);
        chk("idle_valid", 32'(m_out_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(m_busy), 32'd0);
        chk({tag, "_done"},  32'(m_done), 32'd0);
        chk({tag, "_rd_en"}, 32'(m_rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(m_rd_addr), 32'd0);
        chk({tag, "_valid"}, 32'(m_out_valid), 32'd0);
        chk({tag, "_data"},  m_out_data, 32'd0);
        chk({tag, "_oaddr"}, 32'(m_out_addr), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        sel   = 1'b0;
        for (int i = 0; i < 25; i++) mem[i] = 32'(i);
        repeat (3) @(negedge clk);

        // Reset state of both instances
        sel = 1'b0;
        chk_reset_outputs("rst_a");
        sel = 1'b1;
        chk_reset_outputs("rst_b");
        reset = 1'b0;
        @(negedge clk);

        // Nominal 4x4 map of 0..15 with out_ready high
        fill_rdy(0);
        run_map(1'b0, -1);

        // Backpressure: window 1 held for 5 cycles
        fill_rdy(0);
        for (int i = 12; i < 17; i++) rdy[i] = 1'b0;
        run_map(1'b0, -1);

        // Start pulsed while busy must be ignored
        fill_rdy(0);
        run_map(1'b0, 8);

        // Signed compare and ties
        mem[0] = 32'hFFFFFFFF; mem[1] = 32'hFFFFFFF9; mem[4] = 32'h80000000; mem[5] = 32'hFFFFFFFD;
        mem[2] = 32'd5;        mem[3] = 32'd5;        mem[6] = 32'hFFFFFFFE; mem[7] = 32'd5;
        run_map(1'b0, -1);
        chk("signed_max", (res_data.size() > 0) ? res_data[0] : 32'hBAD0BAD0, 32'hFFFFFFFF);
        chk("tie_max",    (res_data.size() > 1) ? res_data[1] : 32'hBAD0BAD0, 32'd5);

        // Non-divisible 5x5 map
        fill_mem_random();
        fill_rdy(30);
        run_map(1'b1, -1);

        // Reset in the middle of window 2's reads
        fill_mem_random();
        sel   = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        chk("mid_rd_en", 32'(m_rd_en), 32'd1);
        chk("mid_rd_addr", 32'(m_rd_addr), 32'd9);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_outputs("mid_rst");
        repeat (3) @(negedge clk);
        chk("post_rst_rd_en", 32'(m_rd_en), 32'd0);
        chk("post_rst_valid", 32'(m_out_valid), 32'd0);
        fill_rdy(0);
        run_map(1'b0, -1);

        // Reset and start together: start is dropped
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_start_busy", 32'(m_busy), 32'd0);
        chk("rst_start_rd_en", 32'(m_rd_en), 32'd0);

        // Randomized maps and backpressure on both instances
        for (int r = 0; r < 4; r++) begin
            fill_mem_random();
            fill_rdy(40);
            run_map(r[0], -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool_window_sched.md
Name: pool_window_sched

Overview:
- Sequencing controller for the max-pooling datapath.
- On a start pulse it walks a square feature map held in an external single-port buffer. It issues one read address per cycle, in window order.
- Each pooling window is reduced to its signed maximum. Each window result is presented on a valid/ready output port together with its output index.
- Sits between the feature-map buffer (conv output) and the pooled-map writer. It replaces the fully parallel combinational pooling array in area-constrained builds.

Parameters:
- input_size, 8, feature-map side length (map is input_size x input_size, row-major, 32-bit words).
- pooling_size, 2, window side length; stride equals pooling_size; 1 <= pooling_size <= input_size.
- Derived: out_side = input_size/pooling_size (integer divide); AW = max(1,$clog2(input_size*input_size)); OW = max(1,$clog2(out_side*out_side)).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to process one feature map; ignored while busy=1.
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses (inclusive of last out handshake).
- done  out  1  one-cycle pulse after the final window result is accepted.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  AW  buffer word address = row*input_size+col.
- rd_data  in  32  buffer read data, valid exactly one cycle after rd_en.
- out_valid  out  1  window result available; held until accepted.
- out_ready  in  1  downstream accept.
- out_data  out  32  signed max of current window.
- out_addr  out  OW  pooled-map index = wr*out_side+wc.

Behaviour:
- Reset (synchronous, has priority over everything) forces the following:
  - State IDLE; all counters 0.
  - busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_addr=0.
  - Reset mid-operation abandons the map; any in-flight read data is discarded.
- FSM states: IDLE, READ, FLUSH, OUT, DONE.
- IDLE:
  - start=1 moves to READ, with window counters wr=wc=0 and element counters kr=kc=0.
  - busy goes high the next cycle.
- READ:
  - Every cycle: rd_en=1 and rd_addr=(wr*pooling_size+kr)*input_size + wc*pooling_size+kc.
  - kc increments; on wrap kc returns to 0 and kr increments.
  - After the last element (kr=kc=pooling_size-1) the FSM goes to FLUSH.
- Data capture: rd_data is captured in the cycle after each rd_en.
  - The window's first element loads the max register.
  - Subsequent elements replace it only if strictly greater, using a signed 32-bit compare. Ties keep the earlier value.
- FLUSH: one cycle while the last read returns. Then go to OUT.
- OUT:
  - out_valid=1, out_data=max register, out_addr=wr*out_side+wc.
  - out_data and out_addr are stable while waiting.
  - On out_valid&&out_ready: advance wc. On wc wrap, advance wr.
  - If that was the last window (wr=wc=out_side-1), go to DONE. Otherwise return to READ with kr=kc=0.
  - No reads are issued while in OUT; backpressure therefore stalls the buffer interface.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
  - A start arriving in the DONE cycle is ignored.
- Latency and throughput:
  - Last read of a window in cycle c gives out_valid from cycle c+2.
  - With out_ready tied high, each window takes pooling_size^2+2 cycles.
  - The first read occurs the cycle after start.
- Non-divisible maps: trailing rows and columns beyond out_side*pooling_size are never read.
- pooling_size=1 degenerates to a copy: 3 cycles per element, out_data equals the element.
- Simultaneous reset and start: reset wins, and start is not remembered.

Test Plan:
- input_size=4, pooling_size=2, map = 0..15 row-major, out_ready=1, start at cycle 0:
  - reads in cycles 1-4 use addresses 0,1,4,5;
  - out_valid in cycles 6, 12, 18, 24 with (addr,data) = (0,5), (1,7), (2,13), (3,15);
  - done pulses at cycle 25.
- Signed compare: window values {-1,-7,0x80000000,-3} -> out_data=0xFFFFFFFF. Window {5,5,-2,5} -> 5.
- Backpressure: same stimulus as the first scenario, but out_ready low for 5 cycles on window 1.
  - out_valid/out_data/out_addr stay stable for those cycles.
  - rd_en stays 0 throughout.
  - Window 2's reads start the cycle after acceptance.
- input_size=5, pooling_size=2:
  - only addresses in rows 0-3 and columns 0-3 are read;
  - exactly 4 results are produced;
  - address 4 and addresses 20-24 are never accessed.
- Reset asserted mid-READ of window 2:
  - next cycle all outputs are 0 and state is IDLE;
  - a subsequent start reprocesses from window 0 with correct results.
- start pulsed while busy: ignored, no restart, and the result sequence is identical to the first scenario.
